// File: rtl/memory_stage_pkg.sv
// memory_stage shared types: FSM states, write-back and condition codes.
// Shared by memory_stage and branch_cond.
package memory_stage_pkg;

  typedef logic [15:0] word_t;
  typedef logic [2:0]  reg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } memState_t;

  localparam logic [1:0] WDS_ALU  = 2'b00;
  localparam logic [1:0] WDS_MEM  = 2'b01;
  localparam logic [1:0] WDS_PC   = 2'b10;
  localparam logic [1:0] WDS_FLAG = 2'b11;

  localparam logic [2:0] SF_Z   = 3'b000;
  localparam logic [2:0] SF_NZ  = 3'b001;
  localparam logic [2:0] SF_N   = 3'b010;
  localparam logic [2:0] SF_NN  = 3'b011;
  localparam logic [2:0] SF_Z2  = 3'b100;
  localparam logic [2:0] SF_LT  = 3'b101;
  localparam logic [2:0] SF_LE  = 3'b110;
  localparam logic [2:0] SF_CS  = 3'b111;

  typedef struct packed {
    word_t      aluResult;
    word_t      bjAddr;
    word_t      rd2;
    word_t      pcInc;
    logic       z;
    logic       n;
    logic       ofl;
    logic       cout;
    reg_t       wr;
    logic       regWriteEn;
    logic [1:0] wdSel;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    logic       jump;
    logic       halt;
    logic       errIn;
    logic [2:0] selFlag;
  } exMem_t;

endpackage

// File: rtl/memory_stage_branch_cond.sv
// branch_cond: selects the condition bit from ALU flags by SelFlag.
// Used for both PC redirect and flag write-back.
module branch_cond
  import memory_stage_pkg::*;
(
  input  logic [2:0] selFlag,
  input  logic       z,
  input  logic       n,
  input  logic       ofl,
  input  logic       cout,
  output logic       cond
);

  // Condition decode
  always_comb begin
    cond = 1'b0;
    unique case (selFlag)
      SF_Z:  cond = z;
      SF_NZ: cond = ~z;
      SF_N:  cond = n;
      SF_NN: cond = ~n;
      SF_Z2: cond = z;
      SF_LT: cond = n ^ ofl;
      SF_LE: cond = z | (n ^ ofl);
      SF_CS: cond = cout;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: EX/MEM latch, data-memory req/done FSM, branch resolve.
// Optional MEM_ALIGN_CHK_EN: odd-address memory ops skip access, flag err.
module memory_stage
  import memory_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [15:0] ALUResult,
  input  logic [15:0] BJAddr,
  input  logic [15:0] RD2,
  input  logic [15:0] PCInc,
  input  logic        Z,
  input  logic        N,
  input  logic        Ofl,
  input  logic        Cout,
  input  logic [2:0]  WR,
  input  logic        RegWriteEn,
  input  logic [1:0]  RegWriteDataSel,
  input  logic        MemReadEn,
  input  logic        MemWriteEn,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        Halt,
  input  logic        err_in,
  input  logic [2:0]  SelFlag,
  input  logic        flush,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_done,
  output logic        stall,
  output logic        PCsel,
  output logic [15:0] BJAddr_out,
  output logic [15:0] WD,
  output logic [2:0]  WR_out,
  output logic        wb_valid,
  output logic        halt_out,
  output logic        err
);

  exMem_t    m;
  exMem_t    exIn;
  logic      mValid;
  logic      haltQ;
  memState_t state;
  memState_t stateNxt;
  word_t     rdataQ;
  logic      cond;
  logic      isMem;
  logic      misaligned;
  logic      skipMem;
  logic      memGo;
  logic      complete;

  assign exIn = '{
    aluResult:  ALUResult,
    bjAddr:     BJAddr,
    rd2:        RD2,
    pcInc:      PCInc,
    z:          Z,
    n:          N,
    ofl:        Ofl,
    cout:       Cout,
    wr:         WR,
    regWriteEn: RegWriteEn,
    wdSel:      RegWriteDataSel,
    memRead:    MemReadEn,
    memWrite:   MemWriteEn,
    branch:     Branch,
    jump:       Jump,
    halt:       Halt,
    errIn:      err_in,
    selFlag:    SelFlag
  };

  branch_cond uCond (
    .selFlag (m.selFlag),
    .z       (m.z),
    .n       (m.n),
    .ofl     (m.ofl),
    .cout    (m.cout),
    .cond    (cond)
  );

`ifdef MEM_ALIGN_CHK_EN
  assign misaligned = m.aluResult[0];
`else
  assign misaligned = 1'b0;
`endif

  assign isMem    = mValid & (m.memRead | m.memWrite);
  assign skipMem  = isMem & (haltQ | misaligned);
  assign memGo    = isMem & ~skipMem;
  assign complete = mValid & ~stall;

  // EX/MEM latch, frozen while an access is outstanding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m      <= '0;
      mValid <= 1'b0;
    end else if (!stall) begin
      m      <= exIn;
      mValid <= ex_valid & ~flush;
    end
  end

  // FSM state, load-data capture and sticky halt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rdataQ <= '0;
      haltQ  <= 1'b0;
    end else begin
      state <= stateNxt;
      if (state == WAIT && dmem_done)
        rdataQ <= dmem_rdata;
      if (complete && m.halt)
        haltQ <= 1'b1;
    end
  end

  // Next state, request and stall
  always_comb begin
    stateNxt = state;
    dmem_req = 1'b0;
    stall    = 1'b0;
    unique case (state)
      IDLE: begin
        if (memGo) begin
          dmem_req = 1'b1;
          stall    = 1'b1;
          stateNxt = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (dmem_done)
          stateNxt = DONE;
      end
      DONE: stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // Write-back data select
  always_comb begin
    WD = m.aluResult;
    unique case (m.wdSel)
      WDS_ALU:  WD = m.aluResult;
      WDS_MEM:  WD = rdataQ;
      WDS_PC:   WD = m.pcInc;
      WDS_FLAG: WD = {15'b0, cond};
      default:  WD = m.aluResult;
    endcase
  end

  assign dmem_we    = isMem & m.memWrite;
  assign dmem_addr  = m.aluResult;
  assign dmem_wdata = m.rd2;
  assign PCsel      = complete & (m.jump | (m.branch & cond));
  assign BJAddr_out = m.bjAddr;
  assign WR_out     = m.wr;
  assign wb_valid   = complete & m.regWriteEn & ~skipMem;
  assign halt_out   = haltQ;
  assign err        = (mValid & m.errIn) | (isMem & misaligned);

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: random instructions against a spec-level model.
// Build with +define+MEM_ALIGN_CHK_EN to exercise the alignment check.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [15:0] ALUResult, BJAddr, RD2, PCInc;
  logic        Z, N, Ofl, Cout;
  logic [2:0]  WR;
  logic        RegWriteEn;
  logic [1:0]  RegWriteDataSel;
  logic        MemReadEn, MemWriteEn, Branch, Jump, Halt, err_in;
  logic [2:0]  SelFlag;
  logic        flush;
  logic        dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_done;
  logic        stall, PCsel;
  logic [15:0] BJAddr_out, WD;
  logic [2:0]  WR_out;
  logic        wb_valid, halt_out, err;

  int nChecks = 0;
  int nErrors = 0;
  logic [15:0] lastRd;

`ifdef MEM_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  typedef struct {
    logic [15:0] alu, bj, rd2, pci;
    logic        z, n, o, c;
    logic [2:0]  wr;
    logic        rwe;
    logic [1:0]  sel;
    logic        mr, mw, br, jp, hl, er;
    logic [2:0]  sf;
    int          lat;
    logic [15:0] rdata;
  } instr_t;

  memory_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid),
    .ALUResult(ALUResult), .BJAddr(BJAddr), .RD2(RD2), .PCInc(PCInc),
    .Z(Z), .N(N), .Ofl(Ofl), .Cout(Cout), .WR(WR),
    .RegWriteEn(RegWriteEn), .RegWriteDataSel(RegWriteDataSel),
    .MemReadEn(MemReadEn), .MemWriteEn(MemWriteEn),
    .Branch(Branch), .Jump(Jump), .Halt(Halt), .err_in(err_in),
    .SelFlag(SelFlag), .flush(flush),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_done(dmem_done),
    .stall(stall), .PCsel(PCsel), .BJAddr_out(BJAddr_out),
    .WD(WD), .WR_out(WR_out), .wb_valid(wb_valid),
    .halt_out(halt_out), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic condOf(input logic [2:0] sf, input logic z,
                                  input logic n, input logic o,
                                  input logic c);
    case (sf)
      3'd0: return z;
      3'd1: return !z;
      3'd2: return n;
      3'd3: return !n;
      3'd4: return z;
      3'd5: return n != o;
      3'd6: return z || (n != o);
      default: return c;
    endcase
  endfunction

  function automatic instr_t blank();
    instr_t t;
    t = '{alu: 0, bj: 0, rd2: 0, pci: 0, z: 0, n: 0, o: 0, c: 0,
          wr: 0, rwe: 0, sel: 0, mr: 0, mw: 0, br: 0, jp: 0, hl: 0,
          er: 0, sf: 0, lat: 1, rdata: 0};
    return t;
  endfunction

  function automatic instr_t randInstr();
    instr_t t;
    int kind;
    t = blank();
    t.alu = 16'($urandom); t.bj = 16'($urandom);
    t.rd2 = 16'($urandom); t.pci = 16'($urandom);
    t.z = 1'($urandom); t.n = 1'($urandom);
    t.o = 1'($urandom); t.c = 1'($urandom);
    t.wr = 3'($urandom); t.rwe = 1'($urandom);
    t.sel = 2'($urandom); t.sf = 3'($urandom);
    t.br = 1'($urandom); t.jp = ($urandom_range(0, 3) == 0);
    t.er = ($urandom_range(0, 7) == 0);
    kind = $urandom_range(0, 3);
    t.mr = (kind == 1) || (kind == 3);
    t.mw = (kind == 2) || (kind == 3);
    t.lat = $urandom_range(1, 4);
    t.rdata = 16'($urandom);
    return t;
  endfunction

  task automatic drive(input instr_t t);
    ALUResult = t.alu; BJAddr = t.bj; RD2 = t.rd2; PCInc = t.pci;
    Z = t.z; N = t.n; Ofl = t.o; Cout = t.c; WR = t.wr;
    RegWriteEn = t.rwe; RegWriteDataSel = t.sel;
    MemReadEn = t.mr; MemWriteEn = t.mw; Branch = t.br; Jump = t.jp;
    Halt = t.hl; err_in = t.er; SelFlag = t.sf;
  endtask

  task automatic runInstr(input instr_t t, input string nm);
    int reqCnt, stallCnt, reqCyc;
    logic done, isMem, misal, cnd;
    logic [15:0] expWd;
    isMem = t.mr || t.mw;
    misal = ALIGN && isMem && t.alu[0];
    cnd = condOf(t.sf, t.z, t.n, t.o, t.c);
    @(negedge clk);
    drive(t);
    ex_valid = 1'b1; flush = 1'b0; dmem_done = 1'b0;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    ALUResult = 16'($urandom); RD2 = 16'($urandom);
    BJAddr = 16'($urandom); WR = 3'($urandom);
    reqCnt = 0; stallCnt = 0; reqCyc = -1; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (dmem_req) begin
        reqCnt++;
        if (reqCyc < 0) begin
          reqCyc = k;
          check({nm, " addr"}, dmem_addr, t.alu);
          check({nm, " we"}, dmem_we, t.mw);
          if (t.mw) check({nm, " wdata"}, dmem_wdata, t.rd2);
        end
      end
      if (stall) begin
        stallCnt++;
      end else begin
        done = 1'b1;
        if (isMem && !misal) lastRd = t.rdata;
        case (t.sel)
          2'd0: expWd = t.alu;
          2'd1: expWd = lastRd;
          2'd2: expWd = t.pci;
          default: expWd = {15'd0, cnd};
        endcase
        check({nm, " WD"}, WD, expWd);
        check({nm, " wb_valid"}, wb_valid, t.rwe && !misal);
        check({nm, " PCsel"}, PCsel, t.jp || (t.br && cnd));
        check({nm, " BJAddr_out"}, BJAddr_out, t.bj);
        check({nm, " WR_out"}, WR_out, t.wr);
        check({nm, " err"}, err, t.er || misal);
      end
      if (reqCyc >= 0 && k == reqCyc + t.lat) begin
        dmem_done = 1'b1;
        dmem_rdata = t.rdata;
      end else begin
        if (reqCyc < 0 || k == reqCyc || k > reqCyc + t.lat)
          dmem_done = 1'(($urandom));
        else
          dmem_done = 1'b0;
        dmem_rdata = 16'($urandom);
      end
      flush = stall ? 1'($urandom) : 1'b0;
    end
    check({nm, " completed"}, done, 1'b1);
    if (isMem && !misal) begin
      check({nm, " reqCnt"}, reqCnt, 1);
      check({nm, " reqCyc"}, reqCyc, 0);
      check({nm, " stallCnt"}, stallCnt, t.lat + 1);
    end else begin
      check({nm, " reqCnt"}, reqCnt, 0);
      check({nm, " stallCnt"}, stallCnt, 0);
    end
    dmem_done = 1'b0;
    flush = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string nm);
    check({nm, " stall"}, stall, 0);
    check({nm, " dmem_req"}, dmem_req, 0);
    check({nm, " PCsel"}, PCsel, 0);
    check({nm, " wb_valid"}, wb_valid, 0);
    check({nm, " halt_out"}, halt_out, 0);
    check({nm, " err"}, err, 0);
  endtask

  initial begin
    instr_t t;
    int reqCnt;
    rst_n = 1'b0; ex_valid = 1'b0; flush = 1'b0;
    dmem_done = 1'b0; dmem_rdata = '0;
    drive(blank());
    lastRd = '0;
    repeat (2) @(negedge clk);
    checkIdleOutputs("reset");
    check("reset WD", WD, 0);
    check("reset dmem_addr", dmem_addr, 0);
    rst_n = 1'b1;

    t = blank(); t.alu = 16'h1234; t.wr = 3; t.rwe = 1;
    runInstr(t, "alu");

    t = blank(); t.alu = 16'h0040; t.mr = 1; t.rwe = 1; t.sel = 2'b01;
    t.wr = 5; t.lat = 2; t.rdata = 16'hBEEF;
    runInstr(t, "load");

    t = blank(); t.alu = 16'h0010; t.rd2 = 16'h00AA; t.mw = 1;
    t.lat = 1; t.rdata = 16'h5555;
    runInstr(t, "store");

    t = blank(); t.br = 1; t.sf = 3'b001; t.z = 0; t.bj = 16'h0200;
    runInstr(t, "br_taken");
    t.z = 1;
    runInstr(t, "br_not");

    t = blank(); t.jp = 1; t.rwe = 1; t.sel = 2'b10; t.pci = 16'h0102;
    t.bj = 16'h0800; t.wr = 7;
    runInstr(t, "jal");

    t = blank(); t.rwe = 1; t.jp = 1; t.er = 1;
    @(negedge clk);
    drive(t); ex_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0; flush = 1'b0;
    check("flush wb_valid", wb_valid, 0);
    check("flush PCsel", PCsel, 0);
    check("flush err", err, 0);

    for (int i = 0; i < 200; i++) runInstr(randInstr(), "rand");

    t = blank(); t.alu = 16'h0080; t.mr = 1; t.lat = 20;
    @(negedge clk);
    drive(t); ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    check("rstmid req", dmem_req, 1);
    @(negedge clk);
    check("rstmid wait stall", stall, 1);
    check("rstmid wait req", dmem_req, 0);
    rst_n = 1'b0;
    #1;
    checkIdleOutputs("rstmid");
    lastRd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    t = blank(); t.alu = 16'h0042; t.mr = 1; t.rwe = 1; t.sel = 2'b01;
    t.lat = 1; t.rdata = 16'hCAFE;
    runInstr(t, "postrst");

`ifdef MEM_ALIGN_CHK_EN
    t = blank(); t.alu = 16'h0011; t.mr = 1; t.rwe = 1; t.sel = 2'b01;
    runInstr(t, "misalign");
`endif

    t = blank(); t.hl = 1;
    runInstr(t, "halt");
    @(negedge clk);
    check("halt sticky", halt_out, 1);
    t = blank(); t.alu = 16'h0020; t.mr = 1;
    @(negedge clk);
    drive(t); ex_valid = 1'b1;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    reqCnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (dmem_req) reqCnt++;
    end
    check("halt blocks req", reqCnt, 0);
    check("halt stays", halt_out, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             nChecks, nErrors);
    $finish;
  end

endmodule
